// File: rtl/recon_pkg.sv
// recon_pkg: shared FSM state type and default widths for the response collector.
package recon_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam int NUM_INPUTS_DEF  = 4;
    localparam int NUM_SYNAPSE_DEF = 16;
    localparam int NUM_NEURONS_DEF = 4;
    localparam int ID_W  = $clog2(NUM_NEURONS_DEF);
    localparam int CNT_W = $clog2(NUM_SYNAPSE_DEF) + 1;
    localparam int SEL_W = $clog2(NUM_INPUTS_DEF);
    localparam int NUM_W = $clog2(NUM_NEURONS_DEF + 1);
endpackage

// File: rtl/popcount.sv
// popcount: combinational count of set bits in a W-bit word.
module popcount #(
    parameter int W = 16
) (
    input  logic [W-1:0]       in,
    output logic [$clog2(W):0] count
);
    localparam int CW = $clog2(W) + 1;
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) count = count + CW'(in[i]);
    end
endmodule

// File: rtl/resp_collector.sv
// resp_collector: snapshots per-neuron synapse responses and streams one
// count/fire beat per active neuron, then pulses done.
module resp_collector
    import recon_pkg::*;
#(
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int NUM_SYNAPSE = NUM_SYNAPSE_DEF,
    parameter int NUM_NEURONS = NUM_NEURONS_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(NUM_NEURONS+1)-1:0]   num_neurons,
    input  logic [NUM_SYNAPSE-1:0]             resp_func [NUM_NEURONS-1:0],
    input  logic [$clog2(NUM_SYNAPSE):0]       threshold,
    input  logic                               start,
    output logic                               busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(NUM_NEURONS)-1:0]     out_id,
    output logic [$clog2(NUM_SYNAPSE):0]       out_count,
    output logic                               out_fire,
    output logic                               out_last,
    output logic [NUM_NEURONS-1:0]             fire_vec,
    output logic                               done
);
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int CW = $clog2(NUM_SYNAPSE) + 1;
    localparam int NW = $clog2(NUM_NEURONS + 1);

    if (NUM_INPUTS > NUM_SYNAPSE) begin : g_param_chk
        $error("NUM_INPUTS exceeds NUM_SYNAPSE");
    end

    state_t               state, state_n;
    logic [IW-1:0]        idx;
    logic [NW-1:0]        n_q, n_clamped;
    logic [CW-1:0]        thr_q;
    logic [NUM_SYNAPSE-1:0] snap [NUM_NEURONS-1:0];
    logic                 accept, xfer;

    assign n_clamped = (num_neurons > NW'(NUM_NEURONS)) ? NW'(NUM_NEURONS) : num_neurons;
    assign accept    = (state == IDLE) && start;
    assign xfer      = out_valid && out_ready;

    // Payload comes straight from the registered snapshot, so out_ready never reaches out_valid.
    popcount #(.W(NUM_SYNAPSE)) u_popcount (.in(snap[idx]), .count(out_count));
    assign out_id   = idx;
    assign out_fire = out_count >= thr_q;
    assign out_last = NW'(idx) == (n_q - NW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        out_valid = state == SEND;
        done      = state == DONE;
        if (accept) state_n = (n_clamped == '0) ? DONE : SEND;
        else if (xfer && out_last) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            n_q      <= '0;
            thr_q    <= '0;
            fire_vec <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) snap[i] <= '0;
        end else if (accept) begin
            idx      <= '0;
            n_q      <= n_clamped;
            thr_q    <= threshold;
            fire_vec <= '0;
            snap     <= resp_func;
        end else if (xfer) begin
            fire_vec[idx] <= out_fire;
            if (!out_last) idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_resp_collector.sv
// tb_resp_collector: directed checks of beat payload, stalls, snapshot, reset and clamping.
module tb_resp_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  num_neurons;
    logic [15:0] resp_func [3:0];
    logic [4:0]  threshold;
    logic        start;
    logic        busy, out_valid, out_ready, out_fire, out_last, done;
    logic [1:0]  out_id;
    logic [4:0]  out_count;
    logic [3:0]  fire_vec;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    resp_collector dut (
        .clk(clk), .rst_n(rst_n), .num_neurons(num_neurons), .resp_func(resp_func),
        .threshold(threshold), .start(start), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_count(out_count), .out_fire(out_fire),
        .out_last(out_last), .fire_vec(fire_vec), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic load_a;
        resp_func[0] = 16'h000F;
        resp_func[1] = 16'h00F0;
        resp_func[2] = 16'h0300;
        resp_func[3] = 16'h0000;
    endtask

    task automatic expect_beat(input string t, input int id, input int cnt, input bit fire, input bit last);
        check({t, "_valid"}, 32'(out_valid), 1);
        check({t, "_id"},    32'(out_id), id);
        check({t, "_count"}, 32'(out_count), cnt);
        check({t, "_fire"},  32'(out_fire), 32'(fire));
        check({t, "_last"},  32'(out_last), 32'(last));
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_frame(output int beats, output logic [3:0] fv);
        bit fin = 1'b0;
        beats = 0;
        fv = 'x;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (done) begin
                fv = fire_vec;
                fin = 1'b1;
            end else begin
                if (out_valid && out_ready) beats++;
                step();
            end
        end
        if (!fin) check("frame_timeout", 0, 1);
    endtask

    int cnt_a [4]  = '{4, 4, 2, 0};
    bit fire_a [4] = '{1, 1, 0, 0};
    bit pat [5]    = '{0, 0, 1, 0, 1};
    int cnt_b [2]  = '{3, 8};
    bit fire_b [2] = '{0, 1};
    int xfers, beats;
    logic [3:0] fv;

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; num_neurons = '0; threshold = '0;
        for (int i = 0; i < 4; i++) resp_func[i] = '0;
        step(); step();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fire_vec", 32'(fire_vec), 0);
        rst_n = 1'b1;
        step();

        // basic 4-neuron frame at full throughput
        load_a(); threshold = 3; num_neurons = 4; out_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            expect_beat($sformatf("t1b%0d", k), k, cnt_a[k], fire_a[k], k == 3);
            step();
        end
        check("t1_done", 32'(done), 1);
        check("t1_valid_off", 32'(out_valid), 0);
        check("t1_fire_vec", 32'(fire_vec), 4'b0011);
        step();
        check("t1_done_once", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);

        // empty frame
        num_neurons = 0;
        pulse_start();
        check("t2_done", 32'(done), 1);
        check("t2_valid", 32'(out_valid), 0);
        check("t2_fire_vec", 32'(fire_vec), 0);
        step();
        check("t2_done_once", 32'(done), 0);

        // backpressure
        resp_func[0] = 16'h0007; resp_func[1] = 16'h00FF; threshold = 4; num_neurons = 2; out_ready = 1'b0;
        pulse_start();
        xfers = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready = pat[c];
            expect_beat($sformatf("t3c%0d", c), xfers, cnt_b[xfers], fire_b[xfers], xfers == 1);
            if (out_valid && out_ready) xfers++;
            step();
        end
        check("t3_xfers", xfers, 2);
        check("t3_done", 32'(done), 1);
        check("t3_fire_vec", 32'(fire_vec), 4'b0010);
        out_ready = 1'b1;
        step();

        // inputs change and start re-pulsed mid-frame
        load_a(); threshold = 3; num_neurons = 4;
        pulse_start();
        expect_beat("t4b0", 0, 4, 1, 0);
        step();
        for (int i = 0; i < 4; i++) resp_func[i] = 16'hFFFF;
        start = 1'b1; num_neurons = 1; threshold = 0;
        for (int k = 1; k < 4; k++) begin
            expect_beat($sformatf("t4b%0d", k), k, cnt_a[k], fire_a[k], k == 3);
            step();
        end
        start = 1'b0;
        check("t4_done", 32'(done), 1);
        check("t4_fire_vec", 32'(fire_vec), 4'b0011);
        step();
        check("t4_no_restart", 32'(busy), 0);

        // reset mid-frame
        load_a(); threshold = 3; num_neurons = 4;
        pulse_start();
        step(); step();
        check("t5_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_fire_vec", 32'(fire_vec), 0);
        check("t5_done", 32'(done), 0);
        step();
        check("t5_no_done", 32'(done), 0);
        rst_n = 1'b1;
        step();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            expect_beat($sformatf("t5b%0d", k), k, cnt_a[k], fire_a[k], k == 3);
            step();
        end
        check("t5_done_after", 32'(done), 1);
        check("t5_fire_vec_after", 32'(fire_vec), 4'b0011);
        step();

        // full-scale count and compare
        resp_func[0] = 16'hFFFF; num_neurons = 1; threshold = 16;
        pulse_start();
        expect_beat("t6a", 0, 16, 1, 1);
        step();
        check("t6a_done", 32'(done), 1);
        step();
        threshold = 17;
        pulse_start();
        expect_beat("t6b", 0, 16, 0, 1);
        step();
        check("t6b_fire_vec", 32'(fire_vec), 0);
        step();

        // oversized neuron count is clamped
        load_a(); num_neurons = 7; threshold = 3;
        pulse_start();
        run_frame(beats, fv);
        check("t7_beats", beats, 4);
        check("t7_fire_vec", 32'(fv), 4'b0011);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
